// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: ROM port, decoder-facing instruction port and control inputs.
// master = fetch unit side, slave = ROM/decoder/sequencer side.
interface fetch_unit_if #(
    parameter int PC_WIDTH    = 10,
    parameter int INSTR_WIDTH = 9
);
    logic                   start;
    logic [PC_WIDTH-1:0]    imem_addr;
    logic                   imem_en;
    logic [INSTR_WIDTH-1:0] imem_data;
    logic [INSTR_WIDTH-1:0] instr;
    logic                   instr_valid;
    logic [PC_WIDTH-1:0]    pc_out;
    logic                   stall;
    logic                   branch;
    logic [PC_WIDTH-1:0]    branch_target;
    logic                   halt;
    logic                   done;
    logic [15:0]            fetch_count;

    modport master (
        input  start, imem_data, stall, branch, branch_target, halt,
        output imem_addr, imem_en, instr, instr_valid, pc_out, done, fetch_count
    );

    modport slave (
        output start, imem_data, stall, branch, branch_target, halt,
        input  imem_addr, imem_en, instr, instr_valid, pc_out, done, fetch_count
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, synchronous-ROM driver, stall/branch/halt handling.
// Define FETCH_COUNT_EN to enable the saturating accepted-instruction counter.
module fetch_unit #(
    parameter int                  PC_WIDTH    = 10,
    parameter int                  INSTR_WIDTH = 9,
    parameter logic [PC_WIDTH-1:0] START_ADDR  = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    fetch_unit_if.master bus
);
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_FETCH  = 2'd1,
        S_HALTED = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [PC_WIDTH-1:0]    fetch_pc_q, fetch_pc_d;
    logic [PC_WIDTH-1:0]    pc_out_q, pc_out_d;
    logic                   instr_valid_q, instr_valid_d;
    logic                   done_q, done_d;
    logic                   start_fetch;
    logic                   accept;
    logic [INSTR_WIDTH-1:0] instr_w;

    assign accept = instr_valid_q && !bus.stall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            fetch_pc_q    <= START_ADDR;
            pc_out_q      <= '0;
            instr_valid_q <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            pc_out_q      <= pc_out_d;
            instr_valid_q <= instr_valid_d;
            done_q        <= done_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        fetch_pc_d    = fetch_pc_q;
        pc_out_d      = pc_out_q;
        instr_valid_d = instr_valid_q;
        done_d        = done_q;
        start_fetch   = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d     = S_FETCH;
                    start_fetch = 1'b1;
                end
            end
            S_FETCH: begin
                // Halt outranks a simultaneous branch; both need an accepted instruction.
                if (accept && bus.halt) begin
                    state_d       = S_HALTED;
                    instr_valid_d = 1'b0;
                    done_d        = 1'b1;
                end else if (!bus.stall) begin
                    if (accept && bus.branch) begin
                        fetch_pc_d    = bus.branch_target;
                        instr_valid_d = 1'b0;
                    end else begin
                        pc_out_d      = fetch_pc_q;
                        instr_valid_d = 1'b1;
                        fetch_pc_d    = fetch_pc_q + 1'b1;
                    end
                end
            end
            S_HALTED: begin
                if (bus.start) begin
                    state_d     = S_FETCH;
                    start_fetch = 1'b1;
                    done_d      = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (start_fetch) begin
            fetch_pc_d    = START_ADDR;
            instr_valid_d = 1'b0;
        end
    end

    // ROM is only clocked when the PC advances, so a stalled instr stays put.
    assign bus.imem_en     = (state_q == S_FETCH) && !bus.stall;
    assign bus.imem_addr   = fetch_pc_q;
    assign instr_w         = bus.imem_data;
    assign bus.instr       = instr_w;
    assign bus.instr_valid = instr_valid_q;
    assign bus.pc_out      = pc_out_q;
    assign bus.done        = done_q;

`ifdef FETCH_COUNT_EN
    logic [15:0] count_q, count_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    always_comb begin
        count_d = count_q;
        if (start_fetch) begin
            count_d = '0;
        end else if ((state_q == S_FETCH) && accept && (count_q != 16'hFFFF)) begin
            count_d = count_q + 16'd1;
        end
    end

    assign bus.fetch_count = count_q;
`else
    assign bus.fetch_count = '0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: default-start DUT plus a START_ADDR=3FE DUT for PC wrap.
// ROM content is word(a) = low 9 bits of (a + 16), so ROM[0..3] = 010..013.
module tb_fetch_unit;
    logic clk;
    logic rst_n;
    int   pass_cnt;
    int   total_cnt;
    int   cyc;
    logic [31:0] got;
    logic [31:0] exp;

    fetch_unit_if #(.PC_WIDTH(10), .INSTR_WIDTH(9)) bus0 ();
    fetch_unit_if #(.PC_WIDTH(10), .INSTR_WIDTH(9)) bus1 ();

    fetch_unit #(.PC_WIDTH(10), .INSTR_WIDTH(9), .START_ADDR(10'h000)) u_dut0 (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus0)
    );

    fetch_unit #(.PC_WIDTH(10), .INSTR_WIDTH(9), .START_ADDR(10'h3FE)) u_dut1 (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus1)
    );

    function automatic logic [8:0] rom_word(input logic [9:0] a);
        logic [9:0] s;
        s = a + 10'd16;
        return s[8:0];
    endfunction

    always @(posedge clk) begin
        if (bus0.imem_en) bus0.imem_data <= rom_word(bus0.imem_addr);
        if (bus1.imem_en) bus1.imem_data <= rom_word(bus1.imem_addr);
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        $display("cyc %0d dut0 pc=%h instr=%h valid=%b done=%b | dut1 pc=%h valid=%b",
                 cyc, bus0.pc_out, bus0.instr, bus0.instr_valid, bus0.done,
                 bus1.pc_out, bus1.instr_valid);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus0.start = 1'b0; bus0.stall = 1'b0; bus0.branch = 1'b0;
        bus0.branch_target = '0; bus0.halt = 1'b0;
        bus1.start = 1'b0; bus1.stall = 1'b0; bus1.branch = 1'b0;
        bus1.branch_target = '0; bus1.halt = 1'b0;
        #12;
        got = {bus0.instr_valid, bus0.done, bus0.imem_en, bus0.pc_out};
        exp = {1'b0, 1'b0, 1'b0, 10'h000};
        total_cnt++;
        if (got !== exp) $display("FAIL reset_outputs: got %h expected %h", got, exp);
        else pass_cnt++;
        got = {22'd0, bus0.imem_addr};
        exp = 32'h000;
        total_cnt++;
        if (got !== exp) $display("FAIL reset_fetch_pc0: got %h expected %h", got, exp);
        else pass_cnt++;
        got = {22'd0, bus1.imem_addr};
        exp = 32'h3FE;
        total_cnt++;
        if (got !== exp) $display("FAIL reset_fetch_pc1: got %h expected %h", got, exp);
        else pass_cnt++;
        got = {16'd0, bus0.fetch_count};
        exp = 32'd0;
        total_cnt++;
        if (got !== exp) $display("FAIL reset_count: got %h expected %h", got, exp);
        else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        got = {bus0.instr_valid, bus0.imem_en};
        exp = {1'b0, 1'b0};
        total_cnt++;
        if (got !== exp) $display("FAIL idle_without_start: got %h expected %h", got, exp);
        else pass_cnt++;
    endtask

    task automatic test_startup();
        bus0.start = 1'b1;
        tick();
        bus0.start = 1'b0;
        got = {bus0.instr_valid, bus0.imem_en};
        exp = {1'b0, 1'b1};
        total_cnt++;
        if (got !== exp) $display("FAIL start_first_edge: got %h expected %h", got, exp);
        else pass_cnt++;
        for (int i = 0; i < 3; i++) begin
            tick();
            got = {bus0.instr_valid, bus0.pc_out, bus0.instr};
            exp = {1'b1, 10'(i), 9'(16 + i)};
            total_cnt++;
            if (got !== exp) $display("FAIL stream_pc%0d: got %h expected %h", i, got, exp);
            else pass_cnt++;
        end
    endtask

    task automatic test_stall();
        bus0.stall = 1'b1;
        #1;
        total_cnt++;
        if (bus0.imem_en !== 1'b0) $display("FAIL stall_imem_en: got %b expected 0", bus0.imem_en);
        else pass_cnt++;
        for (int i = 0; i < 3; i++) begin
            tick();
            got = {bus0.instr_valid, bus0.pc_out, bus0.instr, bus0.imem_en};
            exp = {1'b1, 10'h002, 9'h012, 1'b0};
            total_cnt++;
            if (got !== exp) $display("FAIL stall_hold%0d: got %h expected %h", i, got, exp);
            else pass_cnt++;
        end
        bus0.stall = 1'b0;
        tick();
        got = {bus0.instr_valid, bus0.pc_out, bus0.instr};
        exp = {1'b1, 10'h003, 9'h013};
        total_cnt++;
        if (got !== exp) $display("FAIL stall_release: got %h expected %h", got, exp);
        else pass_cnt++;
        tick();
        tick();
        got = {bus0.instr_valid, bus0.pc_out, bus0.instr};
        exp = {1'b1, 10'h005, 9'h015};
        total_cnt++;
        if (got !== exp) $display("FAIL stream_pc5: got %h expected %h", got, exp);
        else pass_cnt++;
    endtask

    task automatic test_branch();
        bus0.branch = 1'b1;
        bus0.branch_target = 10'h040;
        tick();
        bus0.branch = 1'b0;
        total_cnt++;
        if (bus0.instr_valid !== 1'b0) $display("FAIL branch_bubble: got %b expected 0", bus0.instr_valid);
        else pass_cnt++;
        tick();
        got = {bus0.instr_valid, bus0.pc_out, bus0.instr};
        exp = {1'b1, 10'h040, 9'h050};
        total_cnt++;
        if (got !== exp) $display("FAIL branch_target: got %h expected %h", got, exp);
        else pass_cnt++;
    endtask

    task automatic test_halt();
        bus0.branch = 1'b1;
        bus0.branch_target = 10'h007;
        tick();
        bus0.branch = 1'b0;
        tick();
        got = {bus0.instr_valid, bus0.pc_out, bus0.instr};
        exp = {1'b1, 10'h007, 9'h017};
        total_cnt++;
        if (got !== exp) $display("FAIL halt_setup_pc7: got %h expected %h", got, exp);
        else pass_cnt++;
        bus0.halt = 1'b1;
        bus0.branch = 1'b1;
        bus0.branch_target = 10'h100;
        tick();
        bus0.halt = 1'b0;
        bus0.branch = 1'b0;
        got = {bus0.done, bus0.instr_valid, bus0.imem_en};
        exp = {1'b1, 1'b0, 1'b0};
        total_cnt++;
        if (got !== exp) $display("FAIL halt_enter: got %h expected %h", got, exp);
        else pass_cnt++;
        bus0.stall = 1'b1;
        bus0.branch = 1'b1;
        tick();
        tick();
        bus0.stall = 1'b0;
        bus0.branch = 1'b0;
        got = {bus0.done, bus0.instr_valid, bus0.imem_en, bus0.imem_addr};
        exp = {1'b1, 1'b0, 1'b0, 10'h008};
        total_cnt++;
        if (got !== exp) $display("FAIL halt_frozen: got %h expected %h", got, exp);
        else pass_cnt++;
        bus0.start = 1'b1;
        tick();
        bus0.start = 1'b0;
        got = {bus0.done, bus0.instr_valid};
        exp = {1'b0, 1'b0};
        total_cnt++;
        if (got !== exp) $display("FAIL restart_first_edge: got %h expected %h", got, exp);
        else pass_cnt++;
        tick();
        got = {bus0.done, bus0.instr_valid, bus0.pc_out, bus0.instr};
        exp = {1'b0, 1'b1, 10'h000, 9'h010};
        total_cnt++;
        if (got !== exp) $display("FAIL restart_pc0: got %h expected %h", got, exp);
        else pass_cnt++;
    endtask

    task automatic test_branch_same_pc();
        bus0.branch = 1'b1;
        bus0.branch_target = 10'h001;
        tick();
        bus0.branch = 1'b0;
        total_cnt++;
        if (bus0.instr_valid !== 1'b0) $display("FAIL same_pc_bubble: got %b expected 0", bus0.instr_valid);
        else pass_cnt++;
        tick();
        got = {bus0.instr_valid, bus0.pc_out, bus0.instr};
        exp = {1'b1, 10'h001, 9'h011};
        total_cnt++;
        if (got !== exp) $display("FAIL same_pc_target: got %h expected %h", got, exp);
        else pass_cnt++;
    endtask

    task automatic test_ignored_inputs();
        bus0.start = 1'b1;
        tick();
        bus0.start = 1'b0;
        got = {bus0.instr_valid, bus0.pc_out};
        exp = {1'b1, 10'h002};
        total_cnt++;
        if (got !== exp) $display("FAIL start_in_fetch: got %h expected %h", got, exp);
        else pass_cnt++;
        bus0.stall = 1'b1;
        bus0.halt = 1'b1;
        bus0.branch = 1'b1;
        bus0.branch_target = 10'h200;
        tick();
        got = {bus0.done, bus0.instr_valid, bus0.pc_out};
        exp = {1'b0, 1'b1, 10'h002};
        total_cnt++;
        if (got !== exp) $display("FAIL stalled_halt_branch: got %h expected %h", got, exp);
        else pass_cnt++;
        bus0.stall = 1'b0;
        bus0.halt = 1'b0;
        bus0.branch = 1'b0;
        tick();
        got = {bus0.instr_valid, bus0.pc_out, bus0.instr};
        exp = {1'b1, 10'h003, 9'h013};
        total_cnt++;
        if (got !== exp) $display("FAIL after_stalled_ctrl: got %h expected %h", got, exp);
        else pass_cnt++;
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 6; i++) tick();
        total_cnt++;
        if (bus0.pc_out !== 10'h009) $display("FAIL pre_reset_pc9: got %h expected 009", bus0.pc_out);
        else pass_cnt++;
        #2;
        rst_n = 1'b0;
        #1;
        got = {bus0.instr_valid, bus0.done, bus0.imem_en, bus0.pc_out, bus0.imem_addr};
        exp = {1'b0, 1'b0, 1'b0, 10'h000, 10'h000};
        total_cnt++;
        if (got !== exp) $display("FAIL async_reset: got %h expected %h", got, exp);
        else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        got = {bus0.instr_valid, bus0.imem_en};
        exp = {1'b0, 1'b0};
        total_cnt++;
        if (got !== exp) $display("FAIL post_reset_idle: got %h expected %h", got, exp);
        else pass_cnt++;
    endtask

    task automatic test_wrap();
        bus1.start = 1'b1;
        tick();
        bus1.start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            got = {bus1.instr_valid, bus1.pc_out, bus1.instr};
            exp = {1'b1, 10'(10'h3FE + i), rom_word(10'(10'h3FE + i))};
            total_cnt++;
            if (got !== exp) $display("FAIL wrap_step%0d: got %h expected %h", i, got, exp);
            else pass_cnt++;
        end
    endtask

    task automatic test_fetch_count();
        bus0.start = 1'b1;
        tick();
        bus0.start = 1'b0;
        total_cnt++;
        if (bus0.fetch_count !== 16'd0) $display("FAIL count_after_start: got %h expected 0000", bus0.fetch_count);
        else pass_cnt++;
        for (int i = 0; i < 5; i++) tick();
`ifdef FETCH_COUNT_EN
        exp = 32'd4;
`else
        exp = 32'd0;
`endif
        got = {16'd0, bus0.fetch_count};
        total_cnt++;
        if (got !== exp) $display("FAIL count_four_accepts: got %h expected %h", got, exp);
        else pass_cnt++;
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        cyc       = 0;
        test_reset();
        test_startup();
        test_stall();
        test_branch();
        test_halt();
        test_branch_same_pc();
        test_ignored_inputs();
        test_async_reset();
        test_wrap();
        test_fetch_count();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
